// File: rtl/dff_pipe_if.sv
// dff_pipe_if: bundles the pipeline's control, data, tap and status signals.
interface dff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [TW-1:0]    tap_sel;
    logic [WIDTH-1:0] tap_q;
    logic             tap_valid;
    logic [OW-1:0]    occupancy;
    modport master (
        output en, flush, d, in_valid, tap_sel,
        input  q, out_valid, tap_q, tap_valid, occupancy
    );
    modport slave (
        input  en, flush, d, in_valid, tap_sel,
        output q, out_valid, tap_q, tap_valid, occupancy
    );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: stallable, flushable DEPTH-stage register pipeline with valid
// tracking, occupancy count and a combinational tap.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic         clk,
    input logic         rst_n,
    dff_pipe_if.slave   bus
);
    localparam int OW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [OW-1:0]    r_occ;
    logic             w_tap_ok;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
            r_vld <= '0;
            r_occ <= '0;
        end else if (bus.en) begin
            r_data[0] <= bus.d;
            r_vld[0]  <= bus.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
            // entering and leaving valids cancel, so occ tracks popcount(vld)
            r_occ <= r_occ + OW'(bus.in_valid) - OW'(r_vld[DEPTH-1]);
        end
    end
    assign w_tap_ok      = 32'(bus.tap_sel) < DEPTH;
    assign bus.tap_q     = w_tap_ok ? r_data[bus.tap_sel] : RESET_VAL;
    assign bus.tap_valid = w_tap_ok ? r_vld[bus.tap_sel] : 1'b0;
    assign bus.q         = r_data[DEPTH-1];
    assign bus.out_valid = r_vld[DEPTH-1];
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: randomized and directed checks of dff_pipe against a
// queue-based model of the last DEPTH enabled inputs.
module tb_dff_pipe;
    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'hA5;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] md[$];
    logic       mv[$];
    always #5 clk = ~clk;
    dff_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
    dff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    dff_pipe_if #(.WIDTH(W), .DEPTH(3)) bus3 ();
    dff_pipe #(.WIDTH(W), .DEPTH(3), .RESET_VAL(RV)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic mclear();
        md.delete();
        mv.delete();
        for (int i = 0; i < D; i++) begin
            md.push_back(RV);
            mv.push_back(1'b0);
        end
    endtask

    function automatic int mocc();
        int n = 0;
        foreach (mv[i]) n += int'(mv[i]);
        return n;
    endfunction

    task automatic cyc(input logic e, input logic f, input logic [7:0] dv, input logic v);
        bus.en = e;
        bus.flush = f;
        bus.d = dv;
        bus.in_valid = v;
        @(posedge clk);
        if (f) mclear();
        else if (e) begin
            md.push_front(dv);
            mv.push_front(v);
            void'(md.pop_back());
            void'(mv.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        bus.tap_sel = 2'd0;
        bus3.en = 1'b0; bus3.flush = 1'b0; bus3.d = '0; bus3.in_valid = 1'b0; bus3.tap_sel = 2'd3;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        mclear();
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'h30 + k), 1'b1);
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got %b exp 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        mclear();
        #1;
        total++;
        if (bus.q !== RV || bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.tap_q !== RV || bus.tap_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset got q=%h ov=%b occ=%0d tq=%h tv=%b exp a5/0/0/a5/0",
                bus.q, bus.out_valid, bus.occupancy, bus.tap_q, bus.tap_valid);
        end
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 1'($urandom));
            total++;
            if (bus.q !== RV || bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
                bad++; $display("FAIL idle_after_reset k=%0d got q=%h ov=%b occ=%0d exp a5/0/0", k, bus.q, bus.out_valid, bus.occupancy);
            end
        end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 8'(k), 1'b1);
            total++;
            if (bus.occupancy !== 3'(k < D ? k : D)) begin
                bad++; $display("FAIL stream_occ k=%0d got %0d exp %0d", k, bus.occupancy, (k < D ? k : D));
            end
            total++;
            if (k >= D && (bus.q !== 8'(k - D + 1) || bus.out_valid !== 1'b1)) begin
                bad++; $display("FAIL stream_q k=%0d got %h/%b exp %h/1", k, bus.q, bus.out_valid, 8'(k - D + 1));
            end else if (k < D && bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL stream_early k=%0d got ov=%b exp 0", k, bus.out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] q0;
        logic [2:0] o0;
        cyc(1'b1, 1'b0, 8'h11, 1'b1);
        cyc(1'b1, 1'b0, 8'h22, 1'b1);
        q0 = bus.q;
        o0 = bus.occupancy;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 8'(k[0] ? 8'hFF : 8'h00), 1'($urandom));
            total++;
            if (bus.q !== q0 || bus.occupancy !== o0 || bus.q !== md[D-1]) begin
                bad++; $display("FAIL stall k=%0d got q=%h occ=%0d exp q=%h occ=%0d", k, bus.q, bus.occupancy, q0, o0);
            end
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        total++;
        if (bus.q !== 8'h11 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL stall_resume got %h/%b exp 11/1", bus.q, bus.out_valid);
        end
    endtask

    task automatic test_bubbles();
        logic [4:0] pat = 5'b01101;
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 8'($urandom), k < 5 ? pat[k] : 1'b0);
            total++;
            if (bus.out_valid !== ((k >= 3 && k < 8) ? pat[k-3] : 1'b0) || bus.occupancy !== 3'(mocc())) begin
                bad++; $display("FAIL bubbles k=%0d got ov=%b occ=%0d exp ov=%b occ=%0d", k, bus.out_valid, bus.occupancy,
                    (k >= 3 && k < 8) ? pat[k-3] : 1'b0, mocc());
            end
        end
    endtask

    task automatic test_flush();
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h60 + k), 1'b1);
        total++;
        if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL preflush_occ got %0d exp 3", bus.occupancy); end
        cyc(1'b1, 1'b1, 8'h77, 1'b1);
        total++;
        if (bus.occupancy !== 3'd0 || bus.q !== RV || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush got occ=%0d q=%h ov=%b exp 0/a5/0", bus.occupancy, bus.q, bus.out_valid);
        end
        for (int s = 0; s < D; s++) begin
            bus.tap_sel = 2'(s);
            #1;
            total++;
            if (bus.tap_valid !== 1'b0 || bus.tap_q !== RV) begin
                bad++; $display("FAIL flush_tap s=%0d got %h/%b exp a5/0", s, bus.tap_q, bus.tap_valid);
            end
        end
        for (int k = 0; k < D + 1; k++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            total++;
            if (bus.out_valid !== 1'b0 || bus.q === 8'h77) begin
                bad++; $display("FAIL flush_leak k=%0d got %h/%b exp no 77, ov=0", k, bus.q, bus.out_valid);
            end
        end
    endtask

    task automatic test_tap();
        for (int k = 0; k < 40; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom));
            for (int s = 0; s < D; s++) begin
                bus.tap_sel = 2'(s);
                #1;
                total++;
                if (bus.tap_q !== md[s] || bus.tap_valid !== mv[s]) begin
                    bad++; $display("FAIL tap k=%0d s=%0d got %h/%b exp %h/%b", k, s, bus.tap_q, bus.tap_valid, md[s], mv[s]);
                end
            end
            total++;
            if (bus.q !== md[D-1] || bus.out_valid !== mv[D-1] || bus.occupancy !== 3'(mocc())) begin
                bad++; $display("FAIL random k=%0d got q=%h ov=%b occ=%0d exp %h/%b/%0d", k, bus.q, bus.out_valid,
                    bus.occupancy, md[D-1], mv[D-1], mocc());
            end
        end
        bus3.tap_sel = 2'd3;
        #1;
        total++;
        if (bus3.tap_q !== RV || bus3.tap_valid !== 1'b0) begin
            bad++; $display("FAIL tap_oor got %h/%b exp a5/0", bus3.tap_q, bus3.tap_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_flush();
        test_tap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
